pattern_serializer: RTL

PATTERN_SERIALIZER -- requirements
Module: pattern_serializer

---
 rtl/pattern_pkg.sv | 18 +
 rtl/pattern_shift_reg.sv | 59 +++++
 rtl/pattern_serializer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/pattern_pkg.sv
// ---------------------------------------------------------------------------
// pattern_pkg
// Shared definitions for the pattern serializer slice.
//   state_e           : serializer FSM states (IDLE, SHIFT)
//   DEFAULT_WIDTH     : default parallel word width
//   DEFAULT_MSB_FIRST : default shift order (1 = bit WIDTH-1 leaves first)
// ---------------------------------------------------------------------------
package pattern_pkg;

  localparam int DEFAULT_WIDTH     = 8;
  localparam int DEFAULT_MSB_FIRST = 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/pattern_shift_reg.sv
// ---------------------------------------------------------------------------
// pattern_shift_reg
// WIDTH-bit load/shift register feeding the serial output.
// Ports:
//   clk        : clock, rising edge
//   rstb       : asynchronous active-low reset (clears the register)
//   load_i     : parallel load of loadData_i (wins over shift_i)
//   loadData_i : word to load
//   shift_i    : advance one bit toward the output end
//   bit_o      : bit currently presented at the output end
// Parameters:
//   WIDTH      : register width
//   MSB_FIRST  : 1 = output bit WIDTH-1 and shift left, 0 = output bit 0
//                and shift right
// ---------------------------------------------------------------------------
module pattern_shift_reg
  import pattern_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MSB_FIRST = DEFAULT_MSB_FIRST
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             load_i,
  input  logic [WIDTH-1:0] loadData_i,
  input  logic             shift_i,
  output logic             bit_o
);

  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;

  // Next register contents: a load always replaces the word so a new word can
  // start in the same cycle the previous one emits its last bit.
  always_comb begin
    shift_d = shift_q;
    if (load_i) begin
      shift_d = loadData_i;
    end else if (shift_i) begin
      if (MSB_FIRST != 0) begin
        shift_d = {shift_q[WIDTH-2:0], 1'b0};
      end else begin
        shift_d = {1'b0, shift_q[WIDTH-1:1]};
      end
    end
  end

  // Register update; reset clears any partially shifted word.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign bit_o = (MSB_FIRST != 0) ? shift_q[WIDTH-1] : shift_q[0];

endmodule

// File: rtl/pattern_serializer.sv
// ---------------------------------------------------------------------------
// pattern_serializer
// Converts parallel words into a serial bit stream for a downstream pattern
// detector. Each accepted word produces WIDTH consecutive cycles with
// enable=1, starting the cycle after accept.
// Ports:
//   clk            : clock, rising edge
//   rstb           : asynchronous active-low reset
//   flush          : synchronous clear of the word in flight and the buffer
//   data_in        : parallel word
//   data_valid     : data_in is valid
//   data_ready     : word is accepted on an edge where valid and ready are 1
//   serial_pattern : serial bit (0 whenever enable=0)
//   enable         : serial_pattern carries a valid bit
//   busy           : a word is shifting or buffered
// Configuration:
//   PATTERN_SERIALIZER_PREFETCH_EN undefined : ready only in IDLE, one idle
//                                              cycle between words
//   PATTERN_SERIALIZER_PREFETCH_EN defined   : one-entry word buffer, words
//                                              stream back to back
// ---------------------------------------------------------------------------
module pattern_serializer
  import pattern_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MSB_FIRST = DEFAULT_MSB_FIRST
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             flush,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             serial_pattern,
  output logic             enable,
  output logic             busy
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] bitCnt_q;
  logic [CNT_W-1:0] bitCnt_d;
  logic             readyEn_q;
  logic             accept;
  logic             lastBit;
  logic             srLoad;
  logic             srShift;
  logic [WIDTH-1:0] srLoadData;
  logic             srBit;

`ifdef PATTERN_SERIALIZER_PREFETCH_EN
  logic             bufValid_q;
  logic             bufValid_d;
  logic [WIDTH-1:0] bufData_q;
  logic [WIDTH-1:0] bufData_d;
`endif

  // Ready is held off until the first edge after reset release; flush always
  // blocks acceptance so a word cannot slip in while the pipe is cleared.
`ifdef PATTERN_SERIALIZER_PREFETCH_EN
  assign data_ready = readyEn_q && !flush && !bufValid_q;
  assign busy       = (state_q == SHIFT) || bufValid_q;
`else
  assign data_ready = readyEn_q && !flush && (state_q == IDLE);
  assign busy       = (state_q == SHIFT);
`endif

  assign accept         = data_valid && data_ready;
  assign lastBit        = (state_q == SHIFT) && (bitCnt_q == LAST_CNT);
  assign enable         = (state_q == SHIFT);
  assign serial_pattern = enable ? srBit : 1'b0;

  // Next-state logic: decides when the shifter loads, shifts or goes idle,
  // and where an accepted word goes (shifter directly or the buffer).
  always_comb begin
    state_d    = state_q;
    bitCnt_d   = bitCnt_q;
    srLoad     = 1'b0;
    srShift    = 1'b0;
    srLoadData = data_in;
`ifdef PATTERN_SERIALIZER_PREFETCH_EN
    bufValid_d = bufValid_q;
    bufData_d  = bufData_q;
`endif
    if (flush) begin
      state_d  = IDLE;
      bitCnt_d = '0;
`ifdef PATTERN_SERIALIZER_PREFETCH_EN
      bufValid_d = 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            srLoad   = 1'b1;
            state_d  = SHIFT;
            bitCnt_d = '0;
          end
        end
        SHIFT: begin
          srShift = 1'b1;
          if (lastBit) begin
            bitCnt_d = '0;
`ifdef PATTERN_SERIALIZER_PREFETCH_EN
            // A waiting word (buffered, or offered right now with an empty
            // buffer) starts next cycle so enable never drops.
            if (bufValid_q) begin
              srLoad     = 1'b1;
              srLoadData = bufData_q;
              bufValid_d = 1'b0;
            end else if (accept) begin
              srLoad = 1'b1;
            end else begin
              state_d = IDLE;
            end
`else
            state_d = IDLE;
`endif
          end else begin
            bitCnt_d = bitCnt_q + CNT_W'(1);
`ifdef PATTERN_SERIALIZER_PREFETCH_EN
            if (accept) begin
              bufValid_d = 1'b1;
              bufData_d  = data_in;
            end
`endif
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, counter and ready-enable registers; reset abandons any word.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q   <= IDLE;
      bitCnt_q  <= '0;
      readyEn_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bitCnt_q  <= bitCnt_d;
      readyEn_q <= 1'b1;
    end
  end

`ifdef PATTERN_SERIALIZER_PREFETCH_EN
  // One-entry word buffer.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      bufValid_q <= 1'b0;
      bufData_q  <= '0;
    end else begin
      bufValid_q <= bufValid_d;
      bufData_q  <= bufData_d;
    end
  end
`endif

  pattern_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) shiftReg (
    .clk        (clk),
    .rstb       (rstb),
    .load_i     (srLoad),
    .loadData_i (srLoadData),
    .shift_i    (srShift),
    .bit_o      (srBit)
  );

endmodule
